// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int W     = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_unit_adder.sv
// 32-bit carry-lookahead adder: 4-bit groups with lookahead between groups.
module muldiv_unit_adder
  import muldiv_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W-1:0] g;
  logic [W-1:0] p;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin
    logic cg;
    logic c;
    logic gg;
    logic gp;
    int   base;
    sum = '0;
    cg  = ci;
    for (int gi = 0; gi < W / 4; gi++) begin
      base = gi * 4;
      gg = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
         | (p[base+3] & p[base+2] & p[base+1] & g[base]);
      gp = p[base+3] & p[base+2] & p[base+1] & p[base];
      c  = cg;
      for (int k = 0; k < 4; k++) begin
        sum[base+k] = p[base+k] ^ c;
        c = g[base+k] | (p[base+k] & c);
      end
      cg = gg | (gp & cg);
    end
    co = cg;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: one shift-add or restoring-subtract step per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter bit DIV0_SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               sign_a, sign_b, div0_pend;
  logic [W-1:0]       acc_hi, acc_lo, opnd_b;

  logic               take_start, is_signed_in, commit;
  logic [W-1:0]       mag_a, mag_b;
  logic [W-1:0]       add_x, add_y, add_sum;
  logic               add_ci, add_co, no_borrow;
  logic [W-1:0]       fix_hi, fix_lo;
  logic [2*W-1:0]     prod;

  assign busy         = (state != S_IDLE);
  assign take_start   = (state == S_IDLE) && start && !flush;
  assign is_signed_in = ~op[0];
  assign mag_a        = (is_signed_in && a[W-1]) ? neg(a) : a;
  assign mag_b        = (is_signed_in && b[W-1]) ? neg(b) : b;
  assign commit       = (state == S_FIX) && !flush;

  // Divide shifts the next dividend bit into the partial remainder before subtracting.
  always_comb begin
    if (op_q[1]) begin
      add_x  = {acc_hi[W-2:0], acc_lo[W-1]};
      add_y  = ~opnd_b;
      add_ci = 1'b1;
    end else begin
      add_x  = acc_hi;
      add_y  = opnd_b;
      add_ci = 1'b0;
    end
  end

  muldiv_unit_adder u_adder (
    .x   (add_x),
    .y   (add_y),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co)
  );

  // The shifted-out remainder MSB makes the trial 33 bits wide.
  assign no_borrow = acc_hi[W-1] | add_co;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take_start) begin
          state_next = (op[1] && (b == '0)) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) state_next = S_IDLE;
        else if (cnt == CNT_W'(ITERS - 1)) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fix_hi = hi;
    fix_lo = lo;
    prod   = {acc_hi, acc_lo};
    if (!op_q[1]) begin
      if (sign_a ^ sign_b) prod = ~prod + 1'b1;
      fix_hi = prod[2*W-1:W];
      fix_lo = prod[W-1:0];
    end else if (div0_pend) begin
      if (DIV0_SAT) begin
        fix_lo = '1;
        fix_hi = sign_a ? neg(acc_lo) : acc_lo;
      end
    end else begin
      fix_lo = (sign_a ^ sign_b) ? neg(acc_lo) : acc_lo;
      fix_hi = sign_a ? neg(acc_hi) : acc_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= OP_MULT;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div0_pend <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd_b    <= '0;
      done      <= 1'b0;
      div0      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= state_next;
      done  <= commit;
      case (state)
        S_IDLE: begin
          if (take_start) begin
            op_q      <= op;
            sign_a    <= is_signed_in & a[W-1];
            sign_b    <= is_signed_in & b[W-1];
            div0_pend <= op[1] && (b == '0);
            acc_hi    <= '0;
            acc_lo    <= mag_a;
            opnd_b    <= mag_b;
            cnt       <= '0;
            div0      <= 1'b0;
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (!op_q[1]) begin
              if (acc_lo[0]) {acc_hi, acc_lo} <= {add_co, add_sum, acc_lo[W-1:1]};
              else           {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[W-1:1]};
            end else begin
              acc_hi <= no_borrow ? add_sum : {acc_hi[W-2:0], acc_lo[W-1]};
              acc_lo <= {acc_lo[W-2:0], no_borrow};
            end
          end
        end
        S_FIX: begin
          if (commit) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            div0 <= div0_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: saturating and non-saturating instances against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div0, busy_n, done_n, div0_n;
  logic [31:0] hi, lo, hi_n, lo_n;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo, n_hi, n_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DIV0_SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.DIV0_SAT(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy_n), .done(done_n), .div0(div0_n), .hi(hi_n), .lo(lo_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // HI/LO that the MIPS instruction leaves behind, from plain integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit sat, inout logic [31:0] mh, inout logic [31:0] ml);
    logic [63:0] p;
    int          sq, sr;
    case (o)
      2'b00: begin
        p = longint'(int'(x)) * longint'(int'(y));
        mh = p[63:32]; ml = p[31:0];
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        mh = p[63:32]; ml = p[31:0];
      end
      2'b10: begin
        if (y == 0) begin
          if (sat) begin mh = x; ml = 32'hFFFFFFFF; end
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          ml = 32'h80000000; mh = 0;
        end else begin
          sq = int'(x) / int'(y);
          sr = int'(x) % int'(y);
          ml = sq; mh = sr;
        end
      end
      default: begin
        if (y == 0) begin
          if (sat) begin mh = x; ml = 32'hFFFFFFFF; end
        end else begin
          ml = x / y; mh = x % y;
        end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit with_lo_we);
    int n;
    bit d0;
    d0 = o[1] && (y == 0);
    op = o; a = x; b = y; start = 1'b1;
    lo_we = with_lo_we; wdata = 32'h0000CAFE;
    step();
    start = 1'b0; lo_we = 1'b0;
    check({tag, "_busy_t1"}, {31'b0, busy}, 32'd1);
    check({tag, "_div0_clr"}, {31'b0, div0}, 32'd0);
    n = 1;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), d0 ? 32'd2 : 32'd34);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_done_ns"}, {31'b0, done_n}, 32'd1);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    model(o, x, y, 1'b1, m_hi, m_lo);
    model(o, x, y, 1'b0, n_hi, n_lo);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    check({tag, "_hi_ns"}, hi_n, n_hi);
    check({tag, "_lo_ns"}, lo_n, n_lo);
    check({tag, "_div0"}, {31'b0, div0}, {31'b0, d0});
    check({tag, "_div0_ns"}, {31'b0, div0_n}, {31'b0, d0});
    step();
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    bit          seen;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 0; b = 0; wdata = 0;
    step(); step();
    rst = 1'b0;
    step();
    m_hi = 0; m_lo = 0; n_hi = 0; n_lo = 0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div0", {31'b0, div0}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = wdata; m_lo = wdata; n_hi = wdata; n_lo = wdata;
    check("mthi_mtlo_hi", hi, m_hi);
    check("mthi_mtlo_lo", lo, m_lo);

    run_op("mult_neg1x2", 2'b00, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_neg1x2_lit_hi", hi, 32'hFFFFFFFF);
    check("mult_neg1x2_lit_lo", lo, 32'hFFFFFFFE);
    run_op("multu_ffx2", 2'b01, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_ffx2_lit_hi", hi, 32'h00000001);
    run_op("multu_ffsq", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_ffsq_lit_hi", hi, 32'hFFFFFFFE);
    check("multu_ffsq_lit_lo", lo, 32'h00000001);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_m7_2_lit_lo", lo, 32'hFFFFFFFD);
    check("div_m7_2_lit_hi", hi, 32'hFFFFFFFF);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 1'b0);
    check("divu_7_2_lit_lo", lo, 32'd3);
    check("divu_7_2_lit_hi", hi, 32'd1);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_lit_lo", lo, 32'h80000000);
    check("div_ovf_lit_hi", hi, 32'd0);
    run_op("divu_by0", 2'b11, 32'h80000000, 32'd0, 1'b0);
    check("divu_by0_lit_lo", lo, 32'hFFFFFFFF);
    check("divu_by0_lit_hi", hi, 32'h80000000);
    run_op("div_neg_by0", 2'b10, 32'hFFFFFF00, 32'd0, 1'b0);
    run_op("div0_clear", 2'b01, 32'd9, 32'd9, 1'b0);

    // MTHI, then a flushed MULT with an ignored second start
    hi_we = 1'b1; wdata = 32'h00001234;
    step();
    hi_we = 1'b0;
    m_hi = wdata; n_hi = wdata;
    op = 2'b00; a = 3; b = 5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    op = 2'b01; a = 32'h77; b = 32'h99; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_nodone", {31'b0, done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done || done_n || busy) seen = 1'b1;
      step();
    end
    check("flush_quiet", {31'b0, seen}, 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // Reset in the middle of a divide
    op = 2'b10; a = 32'h12345678; b = 32'h00000123; start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_hi = 0; m_lo = 0; n_hi = 0; n_lo = 0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    step();
    check("rst_mid_nodone", {31'b0, done}, 32'd0);

    // MTHI while busy is dropped; visible on the instance that keeps HI on divide-by-zero
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD0BAD;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = wdata; m_lo = wdata; n_hi = wdata; n_lo = wdata;
    op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    hi_we = 1'b1; wdata = 32'h0000DEAD;
    step();
    hi_we = 1'b0;
    model(2'b10, 32'd5, 32'd0, 1'b1, m_hi, m_lo);
    model(2'b10, 32'd5, 32'd0, 1'b0, n_hi, n_lo);
    check("busy_we_done", {31'b0, done_n}, 32'd1);
    check("busy_we_hi_ns", hi_n, n_hi);
    check("busy_we_hi", hi, m_hi);
    step();

    run_op("start_lo_we", 2'b01, 32'h00010001, 32'h00000010, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 0;
        1: ry = 32'($urandom_range(1, 15));
        2: ry = 32'hFFFFFFFF;
        3: rx = 32'h80000000;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ro, rx, ry, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
